mem_io_stage: RTL and testbench

Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It takes the EX/MEM bundle (ALU address, store data, control), serves loads and stores from a word-addressed data RAM or a small memory-mapped I/O window (PortOut, synchronized PortIn, change status), and registers the result into the MEM/WB pipeline register consumed by write-back. It also owns the processor's external PortOut register and the PortIn synchronizer.

---
 rtl/mem_io_stage_if.sv | 34 +++
 rtl/mem_io_stage.sv | 153 +++++++++++++++
 tb/tb_mem_io_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_io_stage_if.sv
// rtl/mem_io_stage_if.sv - EX/MEM input bundle and MEM/WB output bundle of the memory stage
interface mem_io_stage_if;
   logic [31:0] alu_result_M;
   logic [31:0] write_data_M;
   logic        mem_read_M;
   logic        mem_write_M;
   logic        reg_write_M;
   logic [1:0]  mem_to_reg_M;
   logic [4:0]  write_register_M;
   logic [31:0] pc_plus_4_M;
   logic        flush_M;

   logic [31:0] alu_result_W;
   logic [31:0] read_data_W;
   logic [31:0] pc_plus_4_W;
   logic        reg_write_W;
   logic [1:0]  mem_to_reg_W;
   logic [4:0]  write_register_W;
   logic        mem_fault_W;

   modport master (
      output alu_result_M, write_data_M, mem_read_M, mem_write_M, reg_write_M,
             mem_to_reg_M, write_register_M, pc_plus_4_M, flush_M,
      input  alu_result_W, read_data_W, pc_plus_4_W, reg_write_W,
             mem_to_reg_W, write_register_W, mem_fault_W
   );

   modport slave (
      input  alu_result_M, write_data_M, mem_read_M, mem_write_M, reg_write_M,
             mem_to_reg_M, write_register_M, pc_plus_4_M, flush_M,
      output alu_result_W, read_data_W, pc_plus_4_W, reg_write_W,
             mem_to_reg_W, write_register_W, mem_fault_W
   );
endinterface

// File: rtl/mem_io_stage.sv
// rtl/mem_io_stage.sv - MIPS memory stage: data RAM, memory-mapped PortOut/PortIn/STATUS, MEM/WB register
module mem_io_stage #(
   parameter int          DATA_DEPTH = 256,
   parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
   input  logic         clk,
   input  logic         reset,
   mem_io_stage_if.slave bus,
   input  logic [7:0]   PortIn,
   output logic [31:0]  PortOut
);
   localparam int          IDX_W     = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * DATA_DEPTH);

   logic [31:0] ram_q [DATA_DEPTH];

   logic [31:0] alu_result_q, alu_result_d;
   logic [31:0] read_data_q, read_data_d;
   logic [31:0] pc_plus_4_q, pc_plus_4_d;
   logic        reg_write_q, reg_write_d;
   logic [1:0]  mem_to_reg_q, mem_to_reg_d;
   logic [4:0]  write_register_q, write_register_d;
   logic        mem_fault_q, mem_fault_d;
   logic [31:0] port_out_q, port_out_d;
   logic [7:0]  sync1_q, sync1_d;
   logic [7:0]  sync2_q, sync2_d;
   logic [7:0]  prev_q, prev_d;
   logic        chg_q, chg_d;

   logic [31:0] addr;
   logic [31:0] ram_off;
   logic [IDX_W-1:0] ram_idx;
   logic        is_rd, is_wr, both_rw, aligned;
   logic        ram_hit, io_out_hit, io_in_hit, io_st_hit;
   logic        rd_ok, wr_ok, fault;
   logic        ram_we, port_we, status_rd;
   logic [31:0] rdata;

   // Address decode; the unsigned offset compare also rejects addresses below DATA_BASE
   always_comb begin
      addr       = bus.alu_result_M;
      ram_off    = addr - DATA_BASE;
      ram_idx    = IDX_W'(ram_off >> 2);
      ram_hit    = (ram_off < RAM_BYTES);
      io_out_hit = (addr == IO_BASE);
      io_in_hit  = (addr == IO_BASE + 32'd4);
      io_st_hit  = (addr == IO_BASE + 32'd8);
      aligned    = (addr[1:0] == 2'b00);
      is_rd      = bus.mem_read_M & ~bus.mem_write_M;
      is_wr      = bus.mem_write_M & ~bus.mem_read_M;
      both_rw    = bus.mem_read_M & bus.mem_write_M;
      rd_ok      = is_rd & aligned & (ram_hit | io_out_hit | io_in_hit | io_st_hit);
      wr_ok      = is_wr & aligned & (ram_hit | io_out_hit);
      fault      = ~bus.flush_M & (both_rw | ((is_rd | is_wr) & ~(rd_ok | wr_ok)));
      ram_we     = ~bus.flush_M & wr_ok & ram_hit;
      port_we    = ~bus.flush_M & wr_ok & io_out_hit;
      status_rd  = ~bus.flush_M & rd_ok & io_st_hit;
   end

   always_comb begin
      rdata = 32'd0;
      if (ram_hit) begin
         rdata = ram_q[ram_idx];
      end else if (io_out_hit) begin
         rdata = port_out_q;
      end else if (io_in_hit) begin
         rdata = {24'd0, sync2_q};
      end else if (io_st_hit) begin
         rdata = {31'd0, chg_q};
      end
   end

   always_comb begin
      sync1_d    = PortIn;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      port_out_d = port_we ? bus.write_data_M : port_out_q;
      // A fresh change detect overrides a STATUS read in the same cycle
      if (sync2_q != prev_q) begin
         chg_d = 1'b1;
      end else if (status_rd) begin
         chg_d = 1'b0;
      end else begin
         chg_d = chg_q;
      end
   end

   always_comb begin
      alu_result_d     = 32'd0;
      read_data_d      = 32'd0;
      pc_plus_4_d      = 32'd0;
      reg_write_d      = 1'b0;
      mem_to_reg_d     = 2'd0;
      write_register_d = 5'd0;
      mem_fault_d      = 1'b0;
      if (!bus.flush_M) begin
         alu_result_d     = bus.alu_result_M;
         read_data_d      = rd_ok ? rdata : 32'd0;
         pc_plus_4_d      = bus.pc_plus_4_M;
         reg_write_d      = bus.reg_write_M;
         mem_to_reg_d     = bus.mem_to_reg_M;
         write_register_d = bus.write_register_M;
         mem_fault_d      = fault;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_result_q     <= 32'd0;
         read_data_q      <= 32'd0;
         pc_plus_4_q      <= 32'd0;
         reg_write_q      <= 1'b0;
         mem_to_reg_q     <= 2'd0;
         write_register_q <= 5'd0;
         mem_fault_q      <= 1'b0;
         port_out_q       <= 32'd0;
         sync1_q          <= 8'd0;
         sync2_q          <= 8'd0;
         prev_q           <= 8'd0;
         chg_q            <= 1'b0;
      end else begin
         alu_result_q     <= alu_result_d;
         read_data_q      <= read_data_d;
         pc_plus_4_q      <= pc_plus_4_d;
         reg_write_q      <= reg_write_d;
         mem_to_reg_q     <= mem_to_reg_d;
         write_register_q <= write_register_d;
         mem_fault_q      <= mem_fault_d;
         port_out_q       <= port_out_d;
         sync1_q          <= sync1_d;
         sync2_q          <= sync2_d;
         prev_q           <= prev_d;
         chg_q            <= chg_d;
      end
   end

   // RAM contents survive reset, but a store caught by reset is dropped
   always_ff @(posedge clk) begin
      if (ram_we && reset) begin
         ram_q[ram_idx] <= bus.write_data_M;
      end
   end

   assign bus.alu_result_W     = alu_result_q;
   assign bus.read_data_W      = read_data_q;
   assign bus.pc_plus_4_W      = pc_plus_4_q;
   assign bus.reg_write_W      = reg_write_q;
   assign bus.mem_to_reg_W     = mem_to_reg_q;
   assign bus.write_register_W = write_register_q;
   assign bus.mem_fault_W      = mem_fault_q;
   assign PortOut              = port_out_q;
endmodule

// File: tb/tb_mem_io_stage.sv
// tb/tb_mem_io_stage.sv - scoreboard bench for mem_io_stage with directed load/store/I-O vectors
module tb_mem_io_stage;
   localparam logic [31:0] IO = 32'hFFFF_0000;

   typedef struct {
      logic        regw;
      logic [1:0]  mtr;
      logic [4:0]  wreg;
      logic [31:0] alu;
      logic [31:0] rd;
      logic [31:0] pc;
      logic        flt;
      logic [31:0] po;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   int          total = 0;
   int          bad = 0;
   int          n = 0;
   exp_t        sbq[$];

   mem_io_stage_if bus();

   mem_io_stage dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .PortIn  (PortIn),
      .PortOut (PortOut)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endfunction

   task automatic all_zero(input string tag);
      chk({tag, ".alu"}, bus.alu_result_W, 32'd0);
      chk({tag, ".rdata"}, bus.read_data_W, 32'd0);
      chk({tag, ".pc"}, bus.pc_plus_4_W, 32'd0);
      chk({tag, ".regw"}, 32'(bus.reg_write_W), 32'd0);
      chk({tag, ".mtr"}, 32'(bus.mem_to_reg_W), 32'd0);
      chk({tag, ".wreg"}, 32'(bus.write_register_W), 32'd0);
      chk({tag, ".fault"}, 32'(bus.mem_fault_W), 32'd0);
      chk({tag, ".portout"}, PortOut, 32'd0);
   endtask

   task automatic set_m(input logic rd, input logic wr, input logic fl,
                        input logic [31:0] addr, input logic [31:0] wd);
      n++;
      bus.mem_read_M       = rd;
      bus.mem_write_M      = wr;
      bus.flush_M          = fl;
      bus.alu_result_M     = addr;
      bus.write_data_M     = wd;
      bus.reg_write_M      = n[0];
      bus.mem_to_reg_M     = 2'(n % 3);
      bus.write_register_M = 5'(n);
      bus.pc_plus_4_M      = 32'h0040_0000 + 32'(n) * 32'd4;
   endtask

   task automatic op(input logic rd, input logic wr, input logic fl,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_f, input logic [31:0] exp_po);
      exp_t e;
      @(negedge clk);
      set_m(rd, wr, fl, addr, wd);
      e.regw = fl ? 1'b0 : n[0];
      e.mtr  = fl ? 2'd0 : 2'(n % 3);
      e.wreg = fl ? 5'd0 : 5'(n);
      e.alu  = fl ? 32'd0 : addr;
      e.pc   = fl ? 32'd0 : 32'h0040_0000 + 32'(n) * 32'd4;
      e.rd   = exp_rd;
      e.flt  = exp_f;
      e.po   = exp_po;
      sbq.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("regw", 32'(bus.reg_write_W), 32'(e.regw));
            chk("mtr", 32'(bus.mem_to_reg_W), 32'(e.mtr));
            chk("wreg", 32'(bus.write_register_W), 32'(e.wreg));
            chk("alu", bus.alu_result_W, e.alu);
            chk("rdata", bus.read_data_W, e.rd);
            chk("pc", bus.pc_plus_4_W, e.pc);
            chk("fault", 32'(bus.mem_fault_W), 32'(e.flt));
            chk("portout", PortOut, e.po);
         end
      end
   end

   initial begin : stim
      reset  = 1'b0;
      PortIn = 8'h00;
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      all_zero("reset_init");

      op(1, 0, 0, IO + 4, 0, 32'd0, 0, 32'd0);
      op(0, 1, 0, 32'h1001_0010, 32'hDEAD_BEEF, 32'd0, 0, 32'd0);
      op(1, 0, 0, 32'h1001_0010, 0, 32'hDEAD_BEEF, 0, 32'd0);
      op(0, 1, 0, IO, 32'h0000_00A5, 32'd0, 0, 32'hA5);
      op(1, 0, 0, IO, 0, 32'hA5, 0, 32'hA5);

      op(0, 0, 0, 32'h0000_1234, 0, 32'd0, 0, 32'hA5);
      PortIn = 8'h3C;
      op(1, 0, 0, IO + 4, 0, 32'd0, 0, 32'hA5);
      op(1, 0, 0, IO + 4, 0, 32'h3C, 0, 32'hA5);
      op(1, 0, 0, IO + 8, 0, 32'd1, 0, 32'hA5);
      op(1, 0, 0, IO + 8, 0, 32'd0, 0, 32'hA5);

      op(0, 0, 0, 32'h0000_5678, 0, 32'd0, 0, 32'hA5);
      PortIn = 8'h3D;
      op(1, 0, 0, IO + 8, 0, 32'd0, 0, 32'hA5);
      op(1, 0, 0, IO + 8, 0, 32'd0, 0, 32'hA5);
      op(1, 0, 0, IO + 8, 0, 32'd1, 0, 32'hA5);
      op(1, 0, 0, IO + 8, 0, 32'd0, 0, 32'hA5);

      op(0, 1, 0, 32'h1001_0000, 32'h1122_3344, 32'd0, 0, 32'hA5);
      op(0, 1, 0, 32'h1001_0400, 32'hFFFF_FFFF, 32'd0, 1, 32'hA5);
      op(1, 0, 0, 32'h1001_0002, 0, 32'd0, 1, 32'hA5);
      op(1, 0, 0, 32'h1001_0000, 0, 32'h1122_3344, 0, 32'hA5);
      op(0, 1, 0, 32'h1001_03FC, 32'h0BAD_F00D, 32'd0, 0, 32'hA5);
      op(1, 0, 0, 32'h1001_03FC, 0, 32'h0BAD_F00D, 0, 32'hA5);
      op(0, 1, 0, IO + 4, 32'h0000_0011, 32'd0, 1, 32'hA5);
      op(0, 1, 0, IO + 8, 32'h0000_0022, 32'd0, 1, 32'hA5);
      op(0, 1, 0, IO + 2, 32'h0000_0033, 32'd0, 1, 32'hA5);
      op(1, 1, 0, 32'h1001_0000, 32'd0, 32'd0, 1, 32'hA5);
      op(1, 0, 0, 32'h1001_0000, 0, 32'h1122_3344, 0, 32'hA5);
      op(1, 0, 0, 32'h0000_0100, 0, 32'd0, 1, 32'hA5);
      op(1, 0, 0, 32'h1000_FFFC, 0, 32'd0, 1, 32'hA5);

      op(0, 1, 1, IO, 32'h0000_00FF, 32'd0, 0, 32'hA5);
      op(0, 1, 1, 32'h1001_0010, 32'd0, 32'd0, 0, 32'hA5);
      op(1, 0, 1, 32'h1001_0000, 0, 32'd0, 0, 32'hA5);
      op(1, 0, 0, 32'h1001_0010, 0, 32'hDEAD_BEEF, 0, 32'hA5);
      op(1, 0, 0, IO, 0, 32'hA5, 0, 32'hA5);

      @(negedge clk);
      set_m(1'b0, 1'b1, 1'b0, 32'h1001_0010, 32'h5555_5555);
      #2;
      reset = 1'b0;
      #1;
      all_zero("reset_mid");
      @(negedge clk);
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b1;
      op(1, 0, 0, 32'h1001_0010, 0, 32'hDEAD_BEEF, 0, 32'd0);
      op(1, 0, 0, IO, 0, 32'd0, 0, 32'd0);

      @(negedge clk);
      set_m(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
